// File: rtl/digiclk_timer_sequencer_if.sv
//------------------------------------------------------------------------------
// digiclk_timer_sequencer_if: bus between the sequencer and the 16-bit interval timer slave.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface digiclk_timer_sequencer_if;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic [15:0] tmr_readdata;
   logic        tmr_irq;

   modport master (
      output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      input  tmr_readdata, tmr_irq
   );

   modport slave (
      input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      output tmr_readdata, tmr_irq
   );
endinterface

`default_nettype wire

// File: rtl/digiclk_timer_sequencer.sv
//------------------------------------------------------------------------------
// digiclk_timer_sequencer: programs/services the interval timer and keeps a 24 h hh:mm:ss
// time base. Optional alarm enabled by macro DIGICLK_SEQ_ALARM_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module digiclk_timer_sequencer #(
   parameter logic [31:0] PERIOD = 32'd49999999
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   digiclk_timer_sequencer_if.master  tmr,
   input  wire logic                  set_valid,
   input  wire logic [4:0]            set_hh,
   input  wire logic [5:0]            set_mm,
   input  wire logic [5:0]            set_ss,
   output logic                       set_err,
   output logic [4:0]                 hh,
   output logic [5:0]                 mm,
   output logic [5:0]                 ss,
   output logic                       tick,
   output logic                       busy,
   input  wire logic                  alarm_en,
   input  wire logic [4:0]            alarm_hh,
   input  wire logic [5:0]            alarm_mm,
   input  wire logic                  alarm_ack,
   output logic                       alarm
);

   localparam logic [2:0]  c_ADDR_STAT = 3'd0;
   localparam logic [2:0]  c_ADDR_CTRL = 3'd1;
   localparam logic [2:0]  c_ADDR_PL   = 3'd2;
   localparam logic [2:0]  c_ADDR_PH   = 3'd3;
   localparam logic [15:0] c_CTRL_RUN  = 16'h0007;

   typedef enum logic [3:0] {
      S_WR_PL, S_WR_PH, S_WR_STAT0, S_WR_CTRL, S_IDLE,
      S_RD_STAT, S_CHK_STAT, S_WR_STAT, S_TICK
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        w_cs, w_wr_n, w_tick;
   logic [2:0]  w_addr;
   logic [15:0] w_wdata;

   logic        r_pend, r_set_err;
   logic [4:0]  r_set_hh, r_hh;
   logic [5:0]  r_set_mm, r_set_ss, r_mm, r_ss;
   logic [4:0]  w_hh_inc;
   logic [5:0]  w_mm_inc, w_ss_inc;
   logic        w_set_ok, w_load;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_WR_PL;
      else       r_state <= w_state_nxt;
   end

   // Bus outputs are decoded from state; held idle while reset is asserted.
   always_comb begin
      w_state_nxt = r_state;
      w_cs        = 1'b0;
      w_wr_n      = 1'b1;
      w_addr      = 3'd0;
      w_wdata     = 16'd0;
      w_tick      = 1'b0;
      if (!reset) begin
         case (r_state)
            S_WR_PL: begin
               w_cs = 1'b1; w_wr_n = 1'b0; w_addr = c_ADDR_PL; w_wdata = PERIOD[15:0];
               w_state_nxt = S_WR_PH;
            end
            S_WR_PH: begin
               w_cs = 1'b1; w_wr_n = 1'b0; w_addr = c_ADDR_PH; w_wdata = PERIOD[31:16];
               w_state_nxt = S_WR_STAT0;
            end
            S_WR_STAT0: begin
               w_cs = 1'b1; w_wr_n = 1'b0; w_addr = c_ADDR_STAT;
               w_state_nxt = S_WR_CTRL;
            end
            S_WR_CTRL: begin
               w_cs = 1'b1; w_wr_n = 1'b0; w_addr = c_ADDR_CTRL; w_wdata = c_CTRL_RUN;
               w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
               if (r_pend)           w_state_nxt = S_WR_PL;
               else if (tmr.tmr_irq) w_state_nxt = S_RD_STAT;
            end
            S_RD_STAT: begin
               w_cs = 1'b1; w_addr = c_ADDR_STAT;
               w_state_nxt = S_CHK_STAT;
            end
            S_CHK_STAT: begin
               w_state_nxt = tmr.tmr_readdata[0] ? S_WR_STAT : S_IDLE;
            end
            S_WR_STAT: begin
               w_cs = 1'b1; w_wr_n = 1'b0; w_addr = c_ADDR_STAT;
               w_state_nxt = S_TICK;
            end
            S_TICK: begin
               w_tick = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_WR_PL;
         endcase
      end
   end

   assign w_set_ok = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
   assign w_load   = (r_state == S_IDLE) && r_pend;

   assign w_ss_inc = (r_ss == 6'd59) ? 6'd0 : r_ss + 6'd1;
   assign w_mm_inc = (r_ss != 6'd59) ? r_mm : ((r_mm == 6'd59) ? 6'd0 : r_mm + 6'd1);
   assign w_hh_inc = ((r_ss != 6'd59) || (r_mm != 6'd59)) ? r_hh :
                     ((r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1);

   // A capture in the same cycle the pending set is consumed stays pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend    <= 1'b0;
         r_set_err <= 1'b0;
         r_set_hh  <= 5'd0;
         r_set_mm  <= 6'd0;
         r_set_ss  <= 6'd0;
         r_hh      <= 5'd0;
         r_mm      <= 6'd0;
         r_ss      <= 6'd0;
      end else begin
         r_set_err <= set_valid && !w_set_ok;
         if (w_load) begin
            r_hh   <= r_set_hh;
            r_mm   <= r_set_mm;
            r_ss   <= r_set_ss;
            r_pend <= 1'b0;
         end else if (r_state == S_TICK) begin
            r_hh <= w_hh_inc;
            r_mm <= w_mm_inc;
            r_ss <= w_ss_inc;
         end
         if (set_valid && w_set_ok) begin
            r_pend   <= 1'b1;
            r_set_hh <= set_hh;
            r_set_mm <= set_mm;
            r_set_ss <= set_ss;
         end
      end
   end

`ifdef DIGICLK_SEQ_ALARM_EN
   logic r_alarm;
   always_ff @(posedge clk) begin
      if (reset || alarm_ack)
         r_alarm <= 1'b0;
      else if ((r_state == S_TICK) && alarm_en && (w_hh_inc == alarm_hh) &&
               (w_mm_inc == alarm_mm) && (w_ss_inc == 6'd0))
         r_alarm <= 1'b1;
   end
   assign alarm = r_alarm;
   logic w_unused;
   assign w_unused = &{1'b0, tmr.tmr_readdata[15:1]};
`else
   assign alarm = 1'b0;
   logic w_unused;
   assign w_unused = &{1'b0, alarm_en, alarm_hh, alarm_mm, alarm_ack, tmr.tmr_readdata[15:1]};
`endif

   assign tmr.tmr_chipselect = w_cs;
   assign tmr.tmr_write_n    = w_wr_n;
   assign tmr.tmr_address    = w_addr;
   assign tmr.tmr_writedata  = w_wdata;

   assign set_err = r_set_err;
   assign hh      = r_hh;
   assign mm      = r_mm;
   assign ss      = r_ss;
   assign tick    = w_tick;
   assign busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_digiclk_timer_sequencer.sv
//------------------------------------------------------------------------------
// tb_digiclk_timer_sequencer: directed bench acting as timer slave and button logic.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_digiclk_timer_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       set_valid = 1'b0;
   logic [4:0] set_hh = 5'd0;
   logic [5:0] set_mm = 6'd0;
   logic [5:0] set_ss = 6'd0;
   logic       set_err, tick, busy, alarm;
   logic [4:0] hh;
   logic [5:0] mm, ss;
   logic       alarm_en = 1'b0;
   logic [4:0] alarm_hh = 5'd0;
   logic [5:0] alarm_mm = 6'd0;
   logic       alarm_ack = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

`ifdef DIGICLK_SEQ_ALARM_EN
   localparam logic c_ALARM_EXP = 1'b1;
`else
   localparam logic c_ALARM_EXP = 1'b0;
`endif

   digiclk_timer_sequencer_if bus ();

   digiclk_timer_sequencer #(.PERIOD(32'd49999999)) dut (
      .clk(clk), .reset(reset), .tmr(bus),
      .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
      .set_err(set_err), .hh(hh), .mm(mm), .ss(ss), .tick(tick), .busy(busy),
      .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
      .alarm_ack(alarm_ack), .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic cs, input logic wn,
                          input logic [2:0] a, input logic [15:0] d);
      chk(tag, {11'd0, bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata},
          {11'd0, cs, wn, a, d});
   endtask

   task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s);
      chk(tag, {15'd0, hh, mm, ss}, {15'd0, h, m, s});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From the WR_PL cycle, walk the load sequence and land in IDLE.
   task automatic load_seq(input string tag);
      chk_bus({tag, "_pl"}, 1'b1, 1'b0, 3'd2, 16'hF07F);
      step();
      chk_bus({tag, "_ph"}, 1'b1, 1'b0, 3'd3, 16'h02FA);
      step();
      chk_bus({tag, "_st0"}, 1'b1, 1'b0, 3'd0, 16'h0000);
      step();
      chk_bus({tag, "_ctrl"}, 1'b1, 1'b0, 3'd1, 16'h0007);
      step();
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk_bus({tag, "_idle"}, 1'b0, 1'b1, 3'd0, 16'h0000);
   endtask

   task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s;
      step();
      set_valid = 1'b0;
   endtask

   initial begin
      bus.tmr_irq      = 1'b0;
      bus.tmr_readdata = 16'd0;
      step(); step();
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_flags", {29'd0, tick, set_err, alarm}, 32'd0);
      chk_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
      chk_time("rst_time", 5'd0, 6'd0, 6'd0);

      reset = 1'b0;
      #1;
      load_seq("init");

      // Load 23:59:59, then a valid timeout wraps the day.
      do_set(5'd23, 6'd59, 6'd59);
      chk_time("set_hold", 5'd0, 6'd0, 6'd0);
      step();
      chk_time("set_2359", 5'd23, 6'd59, 6'd59);
      load_seq("reload");
      bus.tmr_irq = 1'b1; bus.tmr_readdata = 16'h0001;
      step();
      chk_bus("rd_stat", 1'b1, 1'b1, 3'd0, 16'h0000);
      step();
      chk_bus("chk_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
      step();
      chk_bus("wr_stat", 1'b1, 1'b0, 3'd0, 16'h0000);
      bus.tmr_irq = 1'b0;
      step();
      chk("tick_hi", {31'd0, tick}, 32'd1);
      chk_time("pre_wrap", 5'd23, 6'd59, 6'd59);
      step();
      chk("tick_lo", {30'd0, tick, busy}, 32'd0);
      chk_time("wrap", 5'd0, 6'd0, 6'd0);

      // Spurious interrupt: TO clear.
      bus.tmr_irq = 1'b1; bus.tmr_readdata = 16'h0000;
      step();
      bus.tmr_irq = 1'b0;
      chk_bus("sp_rd", 1'b1, 1'b1, 3'd0, 16'h0000);
      step();
      step();
      chk("sp_idle", {30'd0, tick, busy}, 32'd0);
      chk_bus("sp_nowr", 1'b0, 1'b1, 3'd0, 16'h0000);
      step();
      chk("sp_notick", {30'd0, tick, busy}, 32'd0);
      chk_time("sp_time", 5'd0, 6'd0, 6'd0);

      // Set arriving during RD_STAT waits for the tick.
      bus.tmr_irq = 1'b1; bus.tmr_readdata = 16'h0001;
      step();
      bus.tmr_irq = 1'b0;
      do_set(5'd12, 6'd34, 6'd56);
      step();
      chk_bus("ms_wrstat", 1'b1, 1'b0, 3'd0, 16'h0000);
      step();
      chk("ms_tick", {31'd0, tick}, 32'd1);
      step();
      chk_time("ms_adv", 5'd0, 6'd0, 6'd1);
      step();
      chk_time("ms_set", 5'd12, 6'd34, 6'd56);
      load_seq("ms");

      // Out-of-range minutes are rejected.
      do_set(5'd1, 6'd60, 6'd0);
      chk("err_hi", {31'd0, set_err}, 32'd1);
      chk_bus("err_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
      step();
      chk("err_lo", {30'd0, set_err, busy}, 32'd0);
      step();
      chk_time("err_time", 5'd12, 6'd34, 6'd56);
      chk_bus("err_bus2", 1'b0, 1'b1, 3'd0, 16'h0000);

      // Alarm at 07:00.
      do_set(5'd6, 6'd59, 6'd59);
      step();
      load_seq("al");
      alarm_en = 1'b1; alarm_hh = 5'd7; alarm_mm = 6'd0;
      bus.tmr_irq = 1'b1;
      step(); step();
      bus.tmr_irq = 1'b0;
      step(); step();
      chk("al_pre", {31'd0, alarm}, 32'd0);
      step();
      chk_time("al_time", 5'd7, 6'd0, 6'd0);
      chk("al_set", {31'd0, alarm}, {31'd0, c_ALARM_EXP});
      step(); step();
      chk("al_hold", {31'd0, alarm}, {31'd0, c_ALARM_EXP});
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      chk("al_ack", {31'd0, alarm}, 32'd0);

      // Reset in the middle of a service sequence.
      bus.tmr_irq = 1'b1;
      step();
      bus.tmr_irq = 1'b0;
      reset = 1'b1;
      step();
      chk("mr_busy", {31'd0, busy}, 32'd1);
      chk_bus("mr_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
      chk_time("mr_time", 5'd0, 6'd0, 6'd0);
      reset = 1'b0;
      #1;
      load_seq("mr");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
